// File: rtl/alu_mul_seq.sv
// Sequential unsigned 16x16 multiplier that borrows the shared combinational ALU
// for its add and shift passes; returns the low product half and an exact overflow flag.
module alu_mul_seq #(
    parameter logic [2:0] OP_ADD  = 3'b000,
    parameter logic [2:0] OP_SHL  = 3'b100,
    parameter logic [2:0] OP_IDLE = 3'b111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        ovfl,
    output logic        alu_gnt,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_r,
    input  logic        alu_ovfl
);

    typedef enum logic [2:0] {
        StIdle,
        StEval,
        StAdd,
        StShl,
        StDone
    } state_t;

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] mcand_q;
    logic [15:0] mplr_q;
    logic        lost_q;
    logic        mplr_rest_zero;

    assign mplr_rest_zero = (mplr_q[15:1] == 15'd0);
    assign alu_gnt        = busy;

    // product is loaded on entry to StDone so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 16'd0;
            mcand_q <= 16'd0;
            mplr_q  <= 16'd0;
            lost_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 16'd0;
            ovfl    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= 16'd0;
                        mcand_q <= op_a;
                        mplr_q  <= op_b;
                        lost_q  <= 1'b0;
                        ovfl    <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    if (mplr_q == 16'd0) begin
                        product <= acc_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (mplr_q[0]) begin
                        state_q <= StAdd;
                    end else begin
                        state_q <= StShl;
                    end
                end
                StAdd: begin
                    acc_q <= alu_r;
                    // A lost multiplicand bit means the true addend is >= 2^16.
                    if (alu_ovfl || lost_q) begin
                        ovfl <= 1'b1;
                    end
                    if (mplr_rest_zero) begin
                        product <= alu_r;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StShl;
                    end
                end
                StShl: begin
                    mcand_q <= alu_r;
                    lost_q  <= lost_q | mcand_q[15];
                    mplr_q  <= mplr_q >> 1;
                    if (mplr_q[1]) begin
                        state_q <= StAdd;
                    end else if (mplr_rest_zero) begin
                        product <= acc_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StShl;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        alu_op = OP_IDLE;
        alu_a  = 16'd0;
        alu_b  = 16'd0;
        unique case (state_q)
            StAdd: begin
                alu_op = OP_ADD;
                alu_a  = acc_q;
                alu_b  = mcand_q;
            end
            StShl: begin
                alu_op = OP_SHL;
                alu_a  = mcand_q;
                alu_b  = 16'd1;
            end
            default: begin
                alu_op = OP_IDLE;
                alu_a  = 16'd0;
                alu_b  = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: random and directed multiplies checked against
// arithmetic reference values, latency and ALU op sequence, plus reset abort.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovfl;
    logic        alu_gnt;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_r;
    logic        alu_ovfl;

    typedef struct {
        logic [15:0] prod;
        logic        ov;
        int          acc_cyc;
        int          lat;
        logic [63:0] seq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    alu_mul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .ovfl     (ovfl),
        .alu_gnt  (alu_gnt),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_r    (alu_r),
        .alu_ovfl (alu_ovfl)
    );

    // Shared ALU stand-in: add with carry, logical shift left, otherwise pass a.
    always_comb begin
        alu_r    = alu_a;
        alu_ovfl = 1'b0;
        case (alu_op)
            3'b000:  {alu_ovfl, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b100:  alu_r = alu_a << alu_b[3:0];
            default: alu_r = alu_a;
        endcase
    end

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic int lat_of(input logic [15:0] b);
        int pc = 0;
        int m = 0;
        if (b == 16'd0) return 2;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                pc++;
                m = i;
            end
        end
        return 2 + pc + m;
    endfunction

    // ALU op sequence as 2-bit codes (1 = add, 2 = shift), earliest op in the low slot.
    function automatic logic [63:0] seq_code(input logic [15:0] b);
        logic [63:0] s = 64'd0;
        int n = 0;
        int m = -1;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        for (int i = 0; i <= m; i++) begin
            if (b[i]) begin
                s = s | (64'd1 << (2 * n));
                n++;
            end
            if (i < m) begin
                s = s | (64'd2 << (2 * n));
                n++;
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h (t=%0t)", name, got, req, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t        e;
        logic [31:0] full;
        full      = 32'(a) * 32'(b);
        e.prod    = full[15:0];
        e.ov      = (full >= 32'h0001_0000);
        e.acc_cyc = acc;
        e.lat     = lat_of(b);
        e.seq     = seq_code(b);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push,
                         output int acc);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc   = cyc;
        if (push) push_exp(a, b, acc);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b);
        int acc;
        issue(a, b, 1'b1, acc);
        wait_until(acc + lat_of(b));
    endtask

    // Monitor: interface invariants every cycle, scoreboard pop on every done.
    initial begin
        logic [63:0] seq;
        int          n;
        logic        done_prev;
        exp_t        e;
        seq       = 64'd0;
        n         = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            checks++;
            if (alu_gnt !== busy
                || (alu_op !== 3'b000 && alu_op !== 3'b100
                    && (alu_op !== 3'b111 || alu_a !== 16'd0 || alu_b !== 16'd0))
                || (alu_op === 3'b100 && alu_b !== 16'd1)
                || (busy !== 1'b1 && alu_op !== 3'b111)
                || (done === 1'b1 && busy !== 1'b1)
                || (!rst_n && (busy !== 1'b0 || done !== 1'b0))) begin
                failures++;
                $display("FAIL alu_iface got gnt=%b busy=%b done=%b op=%b a=%h b=%h rst_n=%b required gnt==busy, op 111 with a=b=0 unless add/shl while busy, shl b=1, idle in reset (t=%0t)",
                         alu_gnt, busy, done, alu_op, alu_a, alu_b, rst_n, $time);
            end
            if (!rst_n) begin
                seq       = 64'd0;
                n         = 0;
                done_prev = 1'b0;
            end else begin
                if (busy === 1'b1 && alu_op === 3'b000 && n < 32) begin
                    seq = seq | (64'd1 << (2 * n));
                    n++;
                end else if (busy === 1'b1 && alu_op === 3'b100 && n < 32) begin
                    seq = seq | (64'd2 << (2 * n));
                    n++;
                end
                if (done === 1'b1) begin
                    chk("done_single_pulse", 64'(done_prev), 64'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done got done=1 product=%h required no done (t=%0t)",
                                 product, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("product", 64'(product), 64'(e.prod));
                        chk("ovfl", 64'(ovfl), 64'(e.ov));
                        chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                        chk("alu_op_seq", seq, e.seq);
                        chk("alu_op_count", 64'(n), 64'(e.lat - 2));
                    end
                    seq = 64'd0;
                    n   = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        int acc;
        int lat;
        int seen;
        int dones;
        logic [15:0] ra;
        logic [15:0] rb;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_ovfl", 64'(ovfl), 64'd0);
        chk("reset_alu_op", 64'(alu_op), 64'(3'b111));
        @(negedge clk);
        rst_n = 1'b1;

        run(16'd3, 16'd5);
        run(16'hFFFF, 16'd0);
        run(16'h8000, 16'd3);
        run(16'h8001, 16'd2);
        run(16'h00FF, 16'h0101);

        // A second start while busy must be dropped.
        issue(16'd7, 16'd9, 1'b1, acc);
        lat = lat_of(16'd9);
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'd5;
        op_b  = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(acc + lat);

        // start held through the done cycle is taken only from IDLE afterwards.
        issue(16'd100, 16'd3, 1'b1, acc);
        lat = lat_of(16'd3);
        wait_until(acc + lat - 1);
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'd11;
        op_b  = 16'd13;
        push_exp(16'd11, 16'd13, acc + lat + 1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(acc + lat + 1 + lat_of(16'd13));

        // Reset during a shift pass aborts with no done.
        issue(16'h1234, 16'h0F0F, 1'b0, acc);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (alu_op === 3'b100) seen = 1;
        end
        chk("reach_shl_before_reset", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_gnt", 64'(alu_gnt), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_alu_op", 64'(alu_op), 64'(3'b111));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("no_done_after_abort", 64'(dones), 64'd0);

        run(16'd2, 16'd2);

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            if (k % 8 == 0) ra = 16'hFFFF;
            run(ra, rb);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
